// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// SAT mode selectors plus the internal arithmetic width rule.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  // One guard bit above the count so MOD == 2**BITS compares and steps cleanly.
  function automatic int calc_width(input int bits);
    return bits + 1;
  endfunction

endpackage

// File: rtl/univ_mod_counter.sv
// Up/down modulo-MOD counter with clear, clamped parallel load, wrap or
// saturate at limits, combinational min/max ticks and a registered wrap pulse.
module univ_mod_counter
  import counter_pkg::*;
#(
  parameter int BITS = 4,
  parameter int MOD  = 10,
  parameter bit SAT  = CNT_WRAP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] d,
  input  logic            en,
  input  logic            up,
  output logic [BITS-1:0] q,
  output logic            max_tick,
  output logic            min_tick,
  output logic            wrap
);

  localparam int            IW    = calc_width(BITS);
  localparam logic [IW-1:0] MOD_W = IW'(MOD);
  localparam logic [IW-1:0] TOP   = IW'(MOD - 1);

  if ((MOD < 2) || (MOD > (2 ** BITS))) begin : g_bad_mod
    $error("univ_mod_counter: MOD=%0d outside legal range 2..2**BITS", MOD);
  end

  logic [BITS-1:0] q_r, q_next;
  logic            wrap_r, wrap_next;
  logic [IW-1:0]   cnt;

  assign cnt = {1'b0, q_r};

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      wrap_r <= wrap_next;
    end
  end

  // Priority clr > load > en; reset is handled in the register itself.
  always_comb begin
    q_next    = q_r;
    wrap_next = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      if ({1'b0, d} < MOD_W) q_next = d;
      else                   q_next = TOP[BITS-1:0];
    end else if (en) begin
      if (up) begin
        if (cnt == TOP) begin
          wrap_next = 1'b1;
          q_next    = SAT ? q_r : '0;
        end else begin
          q_next = BITS'(cnt + IW'(1));
        end
      end else begin
        if (cnt == '0) begin
          wrap_next = 1'b1;
          q_next    = SAT ? q_r : TOP[BITS-1:0];
        end else begin
          q_next = BITS'(cnt - IW'(1));
        end
      end
    end
  end

  always_comb begin
    max_tick = (cnt == TOP);
    min_tick = (q_r == '0);
  end

  assign q    = q_r;
  assign wrap = wrap_r;

endmodule
